// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: parses AA 55 CMD LEN PAYLOAD CSUM frames from a byte receiver and hands them to a consumer
module uart_rx_frame_ctrl #(
  parameter int MAX_LEN     = 16,
  parameter int AW          = 4,
  parameter int TIMEOUT_CYC = 50000,
  parameter int TO_W        = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx_done,
  input  logic [7:0]    rx_data,
  output logic          rx_en,
  output logic          frm_valid,
  input  logic          frm_ack,
  output logic [7:0]    frm_cmd,
  output logic [7:0]    frm_len,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          err_pulse,
  output logic [1:0]    err_code,
  output logic [7:0]    err_cnt
);
  typedef enum logic [2:0] {IDLE, H2, CMD, LEN, DATA, CSUM, HOLD} state_e;
  state_e          state_q, state_d;
  logic [7:0]      cmd_q, cmd_d, len_q, len_d, csum_q, csum_d, err_cnt_q, rd_data_q;
  logic [AW-1:0]   idx_q, idx_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [1:0]      err_code_q, err_d;
  logic            err_pulse_q, frm_valid_q, wr_en, active, timeout;
  logic [7:0]      buf_q [2**AW];
  // next state, frame field capture and error decision; a byte always beats a timeout
  always_comb begin
    active  = state_q inside {H2, CMD, LEN, DATA, CSUM};
    timeout = active && !rx_done && (to_q == TO_W'(TIMEOUT_CYC));
    state_d = state_q;
    cmd_d   = cmd_q;
    len_d   = len_q;
    csum_d  = csum_q;
    idx_d   = idx_q;
    err_d   = 2'b00;
    wr_en   = 1'b0;
    if (timeout) begin
      state_d = IDLE;
      err_d   = 2'b01;
    end else if (rx_done) begin
      case (state_q)
        IDLE: state_d = (rx_data == 8'hAA) ? H2 : IDLE;
        H2:   state_d = (rx_data == 8'h55) ? CMD : (rx_data == 8'hAA) ? H2 : IDLE;
        CMD: begin
          cmd_d   = rx_data;
          csum_d  = rx_data;
          state_d = LEN;
        end
        LEN: begin
          len_d  = rx_data;
          csum_d = csum_q + rx_data;
          idx_d  = '0;
          if (rx_data > 8'(MAX_LEN)) begin
            state_d = IDLE;
            err_d   = 2'b10;
          end else state_d = (rx_data == 8'h00) ? CSUM : DATA;
        end
        DATA: begin
          wr_en   = 1'b1;
          csum_d  = csum_q + rx_data;
          idx_d   = idx_q + 1'b1;
          state_d = (8'(idx_q) == len_q - 8'd1) ? CSUM : DATA;
        end
        CSUM: begin
          state_d = (rx_data == csum_q) ? HOLD : IDLE;
          err_d   = (rx_data == csum_q) ? 2'b00 : 2'b11;
        end
        default: ;
      endcase
    end
    if (state_q == HOLD && frm_ack) state_d = IDLE;
    to_d = (rx_done || !active || state_d == IDLE) ? '0 : to_q + 1'b1;
  end
  // state, frame fields, error reporting and registered buffer read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      len_q       <= '0;
      csum_q      <= '0;
      idx_q       <= '0;
      to_q        <= '0;
      frm_valid_q <= 1'b0;
      err_pulse_q <= 1'b0;
      err_code_q  <= '0;
      err_cnt_q   <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      len_q       <= len_d;
      csum_q      <= csum_d;
      idx_q       <= idx_d;
      to_q        <= to_d;
      frm_valid_q <= (state_d == HOLD);
      err_pulse_q <= |err_d;
      if (|err_d) err_code_q <= err_d;
      if (|err_d && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      rd_data_q   <= buf_q[rd_addr];
    end
  end
  // payload storage, intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_en) buf_q[idx_q] <= rx_data;
  end
  assign rx_en     = (state_q != HOLD);
  assign frm_valid = frm_valid_q;
  assign frm_cmd   = cmd_q;
  assign frm_len   = len_q;
  assign rd_data   = rd_data_q;
  assign err_pulse = err_pulse_q;
  assign err_code  = err_code_q;
  assign err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed frame, error, timeout and reset checks for uart_rx_frame_ctrl
module tb_uart_rx_frame_ctrl;
  localparam int T = 40;
  logic       clk = 1'b0, reset = 1'b1, rx_done = 1'b0, frm_ack = 1'b0;
  logic [7:0] rx_data = '0;
  logic [3:0] rd_addr = '0;
  logic       rx_en, frm_valid, err_pulse;
  logic [7:0] frm_cmd, frm_len, rd_data, err_cnt;
  logic [1:0] err_code;
  int checks = 0, errors = 0;

  uart_rx_frame_ctrl #(.MAX_LEN(16), .AW(4), .TIMEOUT_CYC(T), .TO_W(8)) dut (
    .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data), .rx_en(rx_en),
    .frm_valid(frm_valid), .frm_ack(frm_ack), .frm_cmd(frm_cmd), .frm_len(frm_len),
    .rd_addr(rd_addr), .rd_data(rd_data), .err_pulse(err_pulse), .err_code(err_code),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_done = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_all(input logic [7:0] bytes []);
    foreach (bytes[i]) send(bytes[i]);
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [7:0] exp);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    chk(tag, rd_data, exp);
  endtask

  task automatic ack();
    @(negedge clk);
    frm_ack = 1'b1;
    @(negedge clk);
    frm_ack = 1'b0;
    chk("ack_valid", frm_valid, 0);
    chk("ack_rx_en", rx_en, 1);
  endtask

  initial begin
    #2;
    chk("rst_rx_en", rx_en, 1);
    chk("rst_valid", frm_valid, 0);
    chk("rst_cmd", frm_cmd, 0);
    chk("rst_len", frm_len, 0);
    chk("rst_rd", rd_data, 0);
    chk("rst_err", {err_pulse, err_code, err_cnt}, 0);
    @(negedge clk);
    reset = 1'b0;

    send_all('{8'hAA, 8'h55, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h19});
    chk("f1_valid", frm_valid, 1);
    chk("f1_rx_en", rx_en, 0);
    chk("f1_cmd", frm_cmd, 8'h10);
    chk("f1_len", frm_len, 8'h03);
    rd("f1_rd0", 0, 8'h01);
    rd("f1_rd1", 1, 8'h02);
    rd("f1_rd2", 2, 8'h03);
    chk("f1_still_valid", frm_valid, 1);
    ack();

    send_all('{8'hAA, 8'h55, 8'hFF, 8'h00, 8'hFF});
    chk("z_valid", frm_valid, 1);
    chk("z_len", frm_len, 0);
    chk("z_cmd", frm_cmd, 8'hFF);
    ack();

    send_all('{8'hAA, 8'h55, 8'h80, 8'h02, 8'h80, 8'h01, 8'h03});
    chk("w_valid", frm_valid, 1);
    rd("w_rd0", 0, 8'h80);
    rd("w_rd1", 1, 8'h01);
    ack();

    send_all('{8'h00, 8'hAA, 8'hAA, 8'h55, 8'h05, 8'h00, 8'h05});
    chk("rs_valid", frm_valid, 1);
    chk("rs_cmd", frm_cmd, 8'h05);
    ack();

    send_all('{8'hAA, 8'h12, 8'hAA, 8'h55, 8'h21, 8'h01, 8'h07, 8'h29});
    chk("rs2_valid", frm_valid, 1);
    chk("rs2_cmd", frm_cmd, 8'h21);
    chk("rs2_noerr", err_cnt, 0);
    ack();

    send_all('{8'hAA, 8'h55, 8'h01, 8'h11});
    chk("len_pulse", err_pulse, 1);
    chk("len_code", err_code, 2'b10);
    chk("len_valid", frm_valid, 0);
    @(negedge clk);
    chk("len_pulse_1cyc", err_pulse, 0);

    send_all('{8'hAA, 8'h55, 8'h01, 8'h01, 8'h05, 8'h00});
    chk("cs_pulse", err_pulse, 1);
    chk("cs_code", err_code, 2'b11);
    chk("cs_valid", frm_valid, 0);

    send_all('{8'hAA, 8'h55});
    repeat (T) @(negedge clk);
    chk("to_early", err_pulse, 0);
    @(negedge clk);
    chk("to_pulse", err_pulse, 1);
    chk("to_code", err_code, 2'b01);
    chk("err_cnt3", err_cnt, 3);

    send_all('{8'hAA, 8'h55});
    repeat (T - 1) @(negedge clk);
    send_all('{8'h30, 8'h00, 8'h30});
    chk("bnd_valid", frm_valid, 1);
    chk("bnd_cnt", err_cnt, 3);
    ack();

    send_all('{8'hAA, 8'h55, 8'h40, 8'h04, 8'h01, 8'h02});
    reset = 1'b1;
    #1;
    chk("mr_rx_en", rx_en, 1);
    chk("mr_valid", frm_valid, 0);
    chk("mr_cmd", frm_cmd, 0);
    chk("mr_len", frm_len, 0);
    chk("mr_rd", rd_data, 0);
    chk("mr_err", {err_pulse, err_code, err_cnt}, 0);
    @(negedge clk);
    reset = 1'b0;
    send_all('{8'hAA, 8'h55, 8'h11, 8'h02, 8'hAA, 8'hBB, 8'h78});
    chk("mr_f_valid", frm_valid, 1);
    chk("mr_f_cmd", frm_cmd, 8'h11);
    rd("mr_f_rd1", 1, 8'hBB);
    chk("mr_f_cnt", err_cnt, 0);
    ack();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
